// File: rtl/pcie_cap_cfg_regs.sv
// pcie_cap_cfg_regs
//   PCI Express Capability structure in config space. Takes dword read/write
//   requests from the config TLP decoder and returns one completion per request.
//   Offsets from CAP_BASE:
//     +0  capability list / PCIe capabilities (RO, from parameters)
//     +1  device capabilities (RO, from parameters)
//     +2  {Device Status, Device Control} (live registers)
//     +11 link capabilities 2 (RO, from parameters)
//     other offsets in +0..+14 hit but read 0; anything else misses.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready/write/addr/wdata/be   request channel (dword address)
//   resp_valid/ready/rdata/hit            completion channel
//   err_cor/nonfatal/fatal/ur             error detect strobes into Device Status
//   dev_ctl                   current Device Control value to the core
//   flr_pulse                 one-cycle function level reset strobe
module pcie_cap_cfg_regs #(
    parameter logic [9:0] CAP_BASE    = 10'h01C,
    parameter logic [7:0] NXT_PTR     = 8'h00,
    parameter logic [3:0] PORT_TYPE   = 4'b0000,
    parameter logic [2:0] MPS_SUP     = 3'b001,
    parameter logic       FLR_CAP     = 1'b1,
    parameter logic [4:0] LINK_SPEEDS = 5'b00011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_hit,
    input  logic        err_cor,
    input  logic        err_nonfatal,
    input  logic        err_fatal,
    input  logic        err_ur,
    output logic [15:0] dev_ctl,
    output logic        flr_pulse
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [14:0] CTL_RST = 15'h2810;

    state_t      state;
    logic [14:0] ctl_q;     // bit 15 (FLR initiate) is write-only and never stored
    logic [3:0]  sts_q;     // {ur, fatal, nonfatal, cor}
    logic [14:0] ctl_nxt;
    logic [3:0]  sts_clr;
    logic [3:0]  sts_nxt;
    logic [9:0]  off;
    logic        hit;
    logic        accept;
    logic        wr_devcs;
    logic        flr_go;
    logic [31:0] rdata;
    logic        unused_wdata;

    // Ready is masked by rst so nothing is accepted while reset is held.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Offset wraps to a large value below CAP_BASE, so one compare covers both ends.
    assign off = req_addr - CAP_BASE;
    assign hit = (off <= 10'd14);

    assign dev_ctl = {1'b0, ctl_q};

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off[3:0])
                4'd0:    rdata = {8'h00, PORT_TYPE, 4'h2, NXT_PTR, 8'h10};
                4'd1:    rdata = {3'b000, FLR_CAP, 22'h0, 1'b1, 2'b00, MPS_SUP};
                4'd2:    rdata = {12'h000, sts_q, 1'b0, ctl_q};
                4'd11:   rdata = {26'h0, LINK_SPEEDS, 1'b0};
                default: rdata = '0;
            endcase
        end
    end

    assign wr_devcs = accept && req_write && hit && (off[3:0] == 4'd2);

    always_comb begin
        ctl_nxt = ctl_q;
        if (wr_devcs) begin
            if (req_be[0]) begin
                ctl_nxt[4:0] = req_wdata[4:0];
                // An unsupported max payload size leaves the field as it was.
                if (req_wdata[7:5] <= MPS_SUP)
                    ctl_nxt[7:5] = req_wdata[7:5];
            end
            if (req_be[1])
                ctl_nxt[14:8] = req_wdata[14:8];
        end
    end

    // RW1C status; a new error in the same cycle as a clear keeps the bit set.
    assign sts_clr = (wr_devcs && req_be[2]) ? req_wdata[19:16] : 4'h0;
    assign sts_nxt = (sts_q & ~sts_clr) | {err_ur, err_fatal, err_nonfatal, err_cor};

    assign flr_go = wr_devcs && req_be[1] && req_wdata[15] && FLR_CAP;

    assign unused_wdata = ^req_wdata[31:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_hit   <= 1'b0;
            ctl_q      <= CTL_RST;
            sts_q      <= '0;
            flr_pulse  <= 1'b0;
        end else begin
            ctl_q     <= ctl_nxt;
            sts_q     <= sts_nxt;
            flr_pulse <= flr_go;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= req_write ? 32'h0 : rdata;
                        resp_hit   <= hit;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_cap_cfg_regs.sv
module tb_pcie_cap_cfg_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_hit;
    logic        err_cor, err_nonfatal, err_fatal, err_ur;
    logic [15:0] dev_ctl;
    logic        flr_pulse;

    int checks = 0;
    int failures = 0;
    int flr_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (flr_pulse) flr_cnt++;

    pcie_cap_cfg_regs dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .err_cor(err_cor), .err_nonfatal(err_nonfatal),
        .err_fatal(err_fatal), .err_ur(err_ur),
        .dev_ctl(dev_ctl), .flr_pulse(flr_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full request/completion; err drives the error strobes around the accept edge.
    task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [3:0] err,
                          output logic [31:0] rd, output logic hit);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        {err_ur, err_fatal, err_nonfatal, err_cor} = err;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        {err_ur, err_fatal, err_nonfatal, err_cor} = 4'h0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("resp_valid_timeout", {31'h0, resp_valid}, 32'h1);
        rd = resp_rdata; hit = resp_hit;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic pulse_err(input logic [3:0] err);
        @(negedge clk);
        {err_ur, err_fatal, err_nonfatal, err_cor} = err;
        @(negedge clk);
        {err_ur, err_fatal, err_nonfatal, err_cor} = 4'h0;
    endtask

    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [15:0] exp_ctl;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [31:0] rd;
        logic        hit;
        int          f0;

        vt[0]  = '{1'b0, 10'h01C, 32'h0, 4'h0, 32'h0002_0010, 1'b1, 16'h2810};
        vt[1]  = '{1'b0, 10'h01D, 32'h0, 4'h0, 32'h1000_0021, 1'b1, 16'h2810};
        vt[2]  = '{1'b0, 10'h01E, 32'h0, 4'h0, 32'h0000_2810, 1'b1, 16'h2810};
        vt[3]  = '{1'b0, 10'h027, 32'h0, 4'h0, 32'h0000_0006, 1'b1, 16'h2810};
        vt[4]  = '{1'b0, 10'h01F, 32'h0, 4'h0, 32'h0000_0000, 1'b1, 16'h2810};
        vt[5]  = '{1'b0, 10'h02A, 32'h0, 4'h0, 32'h0000_0000, 1'b1, 16'h2810};
        vt[6]  = '{1'b0, 10'h02B, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 16'h2810};
        vt[7]  = '{1'b0, 10'h01B, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 16'h2810};
        vt[8]  = '{1'b1, 10'h01E, 32'h0000_2830, 4'h3, 32'h0, 1'b1, 16'h2830};
        // MPS 010 unsupported: field stays 001, bit 4 still clears
        vt[9]  = '{1'b1, 10'h01E, 32'h0000_2840, 4'h3, 32'h0, 1'b1, 16'h2820};
        vt[10] = '{1'b1, 10'h01C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 16'h2820};
        vt[11] = '{1'b0, 10'h01C, 32'h0, 4'h0, 32'h0002_0010, 1'b1, 16'h2820};
        vt[12] = '{1'b1, 10'h01E, 32'h0000_0000, 4'h2, 32'h0, 1'b1, 16'h0020};
        vt[13] = '{1'b0, 10'h01E, 32'h0, 4'h0, 32'h0000_0020, 1'b1, 16'h0020};
        vt[14] = '{1'b1, 10'h01E, 32'h0000_2810, 4'h3, 32'h0, 1'b1, 16'h2810};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; resp_ready = 1'b0;
        {err_ur, err_fatal, err_nonfatal, err_cor} = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_hit", {31'h0, resp_hit}, 32'h0);
        chk("rst_dev_ctl", {16'h0, dev_ctl}, 32'h2810);
        chk("rst_flr", {31'h0, flr_pulse}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            do_req(vt[i].w, vt[i].a, vt[i].d, vt[i].be, 4'h0, rd, hit);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vt[i].exp_hit});
            chk($sformatf("vec%0d_dev_ctl", i), {16'h0, dev_ctl}, {16'h0, vt[i].exp_ctl});
        end

        // Status RW1C and set-wins-over-clear
        pulse_err(4'b0100);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("fatal_set", rd, 32'h0004_2810);
        do_req(1'b1, 10'h01E, 32'h0004_0000, 4'h4, 4'b0100, rd, hit);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("fatal_set_wins", rd, 32'h0004_2810);
        do_req(1'b1, 10'h01E, 32'h0004_0000, 4'h4, 4'h0, rd, hit);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("fatal_cleared", rd, 32'h0000_2810);
        pulse_err(4'b1001);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("ur_cor_set", rd, 32'h0009_2810);
        do_req(1'b1, 10'h01E, 32'h0001_0000, 4'h4, 4'h0, rd, hit);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("cor_only_cleared", rd, 32'h0008_2810);
        do_req(1'b1, 10'h01E, 32'h0008_2810, 4'h3, 4'h0, rd, hit);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("clear_needs_be2", rd, 32'h0008_2810);

        // FLR initiate
        f0 = flr_cnt;
        do_req(1'b1, 10'h01E, 32'h0000_8000, 4'h2, 4'h0, rd, hit);
        repeat (3) @(negedge clk);
        chk("flr_one_pulse", flr_cnt - f0, 32'd1);
        chk("flr_dev_ctl", {16'h0, dev_ctl}, 32'h0010);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("flr_reads_0", rd, 32'h0008_0010);
        f0 = flr_cnt;
        do_req(1'b1, 10'h01E, 32'h0000_8000, 4'h1, 4'h0, rd, hit);
        repeat (3) @(negedge clk);
        chk("flr_needs_be1", flr_cnt - f0, 32'd0);
        chk("flr_be0_dev_ctl", {16'h0, dev_ctl}, 32'h0000);

        // Completion backpressure
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h01C;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 10'h01D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), {31'h0, resp_valid}, 32'h1);
            chk($sformatf("bp%0d_rdata", i), resp_rdata, 32'h0002_0010);
            chk($sformatf("bp%0d_hit", i), {31'h0, resp_hit}, 32'h1);
            chk($sformatf("bp%0d_ready", i), {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_done_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_done_ready", {31'h0, req_ready}, 32'h1);

        // Unmapped read, then reset while the completion is pending
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'h040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("unmapped_valid", {31'h0, resp_valid}, 32'h1);
        chk("unmapped_rdata", resp_rdata, 32'h0);
        chk("unmapped_hit", {31'h0, resp_hit}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("post_rst_dev_ctl", {16'h0, dev_ctl}, 32'h2810);
        do_req(1'b0, 10'h01E, 32'h0, 4'h0, 4'h0, rd, hit);
        chk("post_rst_devcs", rd, 32'h0000_2810);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
